atm_ledger_arbiter: RTL and testbench

- Shared-ledger controller that lets N ATM terminals use one single-port account-balance memory (the per-account balance store).
- Round-robin arbitrates terminal transaction requests (balance, withdraw, deposit, transfer).
- Sequences each accepted request as a read-modify-write over the memory port, checks funds, overflow and account range, and returns status plus the resulting source balance.
- Sits between the terminal front-ends and the balance RAM; terminals never access the RAM directly.

---
 rtl/atm_ledger_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_atm_ledger_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_ledger_arbiter.sv
// rtl/atm_ledger_arbiter.sv - round-robin shared-ledger controller for N ATM terminals
//
// Purpose: arbitrates terminal transactions (balance, withdraw, deposit,
// transfer) onto a single-port balance RAM, sequencing each one as a
// read-modify-write with funds, overflow and account-range checks.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req[N_TERM]             per-terminal request level
//   req_op/src/dst/amt      per-terminal request fields, packed terminal 0 in the LSBs
//   gnt[N_TERM]             one-hot pulse, fields of the winner are sampled this cycle
//   done[N_TERM]            one-hot pulse, rsp_status/rsp_balance valid this cycle
//   rsp_status              00 OK, 01 INSUFF, 10 OVERFLOW, 11 BAD_ACC
//   rsp_balance             source balance after the operation
//   busy                    high whenever the sequencer is not idle
//   mem_en/we/addr/wdata    RAM strobe, write enable, address, write data
//   mem_rdata               RAM read data, valid the cycle after a read strobe
module atm_ledger_arbiter #(
    parameter int N_TERM = 4,
    parameter int N_ACC  = 10,
    parameter int ACC_W  = 4,
    parameter int BAL_W  = 16,
    parameter int AMT_W  = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_TERM-1:0]       req,
    input  logic [2*N_TERM-1:0]     req_op,
    input  logic [ACC_W*N_TERM-1:0] req_src,
    input  logic [ACC_W*N_TERM-1:0] req_dst,
    input  logic [AMT_W*N_TERM-1:0] req_amt,
    output logic [N_TERM-1:0]       gnt,
    output logic [N_TERM-1:0]       done,
    output logic [1:0]              rsp_status,
    output logic [BAL_W-1:0]        rsp_balance,
    output logic                    busy,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ACC_W-1:0]        mem_addr,
    output logic [BAL_W-1:0]        mem_wdata,
    input  logic [BAL_W-1:0]        mem_rdata
);

    localparam int PTR_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam logic [ACC_W:0] N_ACC_X = (ACC_W+1)'(N_ACC);

    localparam logic [1:0] OP_BAL  = 2'b00;
    localparam logic [1:0] OP_WD   = 2'b01;
    localparam logic [1:0] OP_DEP  = 2'b10;
    localparam logic [1:0] OP_XFER = 2'b11;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_INSUF = 2'b01;
    localparam logic [1:0] ST_OVF   = 2'b10;
    localparam logic [1:0] ST_BAD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SRC,
        S_CAP_SRC,
        S_CAP_DST,
        S_EXEC,
        S_WR_SRC,
        S_WR_DST,
        S_RESP
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   term_q;
    logic [1:0]         op_q;
    logic [ACC_W-1:0]   src_q;
    logic [ACC_W-1:0]   dst_q;
    logic [AMT_W-1:0]   amt_q;
    logic [BAL_W-1:0]   src_bal_q;
    logic [BAL_W-1:0]   dst_bal_q;
    logic [BAL_W-1:0]   new_src_q;
    logic [BAL_W-1:0]   new_dst_q;
    logic [1:0]         status_q;

    logic [N_TERM-1:0]  gnt_q;
    logic [N_TERM-1:0]  done_q;
    logic [1:0]         rsp_status_q;
    logic [BAL_W-1:0]   rsp_balance_q;
    logic               busy_q;
    logic               mem_en_q;
    logic               mem_we_q;
    logic [ACC_W-1:0]   mem_addr_q;
    logic [BAL_W-1:0]   mem_wdata_q;

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_balance = rsp_balance_q;
    assign busy        = busy_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

    // Round-robin pick: first active request starting at rr_ptr_q.
    logic             win_vld_d;
    logic [PTR_W-1:0] win_d;
    int               scan_k;

    always_comb begin
        win_vld_d = 1'b0;
        win_d     = '0;
        scan_k    = 0;
        for (int i = 0; i < N_TERM; i++) begin
            scan_k = int'(rr_ptr_q) + i;
            if (scan_k >= N_TERM) begin
                scan_k = scan_k - N_TERM;
            end
            if (!win_vld_d && req[scan_k[PTR_W-1:0]]) begin
                win_vld_d = 1'b1;
                win_d     = PTR_W'(scan_k);
            end
        end
    end

    // Fields of the winning terminal.
    logic [1:0]       win_op_d;
    logic [ACC_W-1:0] win_src_d;
    logic [ACC_W-1:0] win_dst_d;
    logic [AMT_W-1:0] win_amt_d;
    logic             win_bad_d;

    always_comb begin
        win_op_d  = '0;
        win_src_d = '0;
        win_dst_d = '0;
        win_amt_d = '0;
        for (int i = 0; i < N_TERM; i++) begin
            if (PTR_W'(i) == win_d) begin
                win_op_d  = req_op[i*2 +: 2];
                win_src_d = req_src[i*ACC_W +: ACC_W];
                win_dst_d = req_dst[i*ACC_W +: ACC_W];
                win_amt_d = req_amt[i*AMT_W +: AMT_W];
            end
        end
        // Range check happens at acceptance so bad requests never touch the RAM.
        win_bad_d = ({1'b0, win_src_d} >= N_ACC_X) ||
                    ((win_op_d == OP_XFER) &&
                     (({1'b0, win_dst_d} >= N_ACC_X) || (win_src_d == win_dst_d)));
    end

    // Arithmetic at BAL_W+1 bits; the carry bit flags overflow so nothing wraps.
    logic [BAL_W-1:0] amt_ext;
    logic [BAL_W:0]   src_sum;
    logic [BAL_W:0]   dst_sum;
    logic [BAL_W-1:0] src_diff;
    logic             insuff;

    assign amt_ext  = BAL_W'(amt_q);
    assign src_sum  = {1'b0, src_bal_q} + {1'b0, amt_ext};
    assign dst_sum  = {1'b0, dst_bal_q} + {1'b0, amt_ext};
    assign src_diff = src_bal_q - amt_ext;
    assign insuff   = (amt_ext > src_bal_q);

    logic [1:0]       exec_status_d;
    logic [BAL_W-1:0] exec_src_d;
    logic [BAL_W-1:0] exec_dst_d;

    // On any failure the balances are left at their read values, so the
    // response balance is simply new_src_q in every case.
    always_comb begin
        exec_status_d = ST_OK;
        exec_src_d    = src_bal_q;
        exec_dst_d    = dst_bal_q;
        case (op_q)
            OP_WD: begin
                if (insuff) begin
                    exec_status_d = ST_INSUF;
                end else begin
                    exec_src_d = src_diff;
                end
            end
            OP_DEP: begin
                if (src_sum[BAL_W]) begin
                    exec_status_d = ST_OVF;
                end else begin
                    exec_src_d = src_sum[BAL_W-1:0];
                end
            end
            OP_XFER: begin
                if (insuff) begin
                    exec_status_d = ST_INSUF;
                end else if (dst_sum[BAL_W]) begin
                    exec_status_d = ST_OVF;
                end else begin
                    exec_src_d = src_diff;
                    exec_dst_d = dst_sum[BAL_W-1:0];
                end
            end
            default: begin
            end
        endcase
    end

    // Read strobes are launched one state ahead so that each CAP state sees
    // valid mem_rdata; write strobes and done appear the cycle after their state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            term_q        <= '0;
            op_q          <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            amt_q         <= '0;
            src_bal_q     <= '0;
            dst_bal_q     <= '0;
            new_src_q     <= '0;
            new_dst_q     <= '0;
            status_q      <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            rsp_status_q  <= '0;
            rsp_balance_q <= '0;
            busy_q        <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            gnt_q    <= '0;
            done_q   <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld_d) begin
                        gnt_q    <= N_TERM'(1) << win_d;
                        term_q   <= win_d;
                        op_q     <= win_op_d;
                        src_q    <= win_src_d;
                        dst_q    <= win_dst_d;
                        amt_q    <= win_amt_d;
                        rr_ptr_q <= (win_d == PTR_W'(N_TERM-1)) ? '0 : win_d + 1'b1;
                        busy_q   <= 1'b1;
                        if (win_bad_d) begin
                            status_q  <= ST_BAD;
                            new_src_q <= '0;
                            state_q   <= S_RESP;
                        end else begin
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= win_src_d;
                            state_q    <= S_RD_SRC;
                        end
                    end
                end
                S_RD_SRC: begin
                    if (op_q == OP_XFER) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= dst_q;
                    end
                    state_q <= S_CAP_SRC;
                end
                S_CAP_SRC: begin
                    src_bal_q <= mem_rdata;
                    state_q   <= (op_q == OP_XFER) ? S_CAP_DST : S_EXEC;
                end
                S_CAP_DST: begin
                    dst_bal_q <= mem_rdata;
                    state_q   <= S_EXEC;
                end
                S_EXEC: begin
                    status_q  <= exec_status_d;
                    new_src_q <= exec_src_d;
                    new_dst_q <= exec_dst_d;
                    if ((exec_status_d == ST_OK) && (op_q != OP_BAL)) begin
                        state_q <= S_WR_SRC;
                    end else begin
                        state_q <= S_RESP;
                    end
                end
                S_WR_SRC: begin
                    mem_en_q    <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= src_q;
                    mem_wdata_q <= new_src_q;
                    state_q     <= (op_q == OP_XFER) ? S_WR_DST : S_RESP;
                end
                S_WR_DST: begin
                    mem_en_q    <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= dst_q;
                    mem_wdata_q <= new_dst_q;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    done_q        <= N_TERM'(1) << term_q;
                    rsp_status_q  <= status_q;
                    rsp_balance_q <= new_src_q;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// tb/tb_atm_ledger_arbiter.sv - self-checking bench for atm_ledger_arbiter
module tb_atm_ledger_arbiter;

    localparam int NT    = 4;
    localparam int ACC_W = 4;
    localparam int BAL_W = 16;
    localparam int AMT_W = 11;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NT-1:0]          req;
    logic [2*NT-1:0]        req_op;
    logic [ACC_W*NT-1:0]    req_src;
    logic [ACC_W*NT-1:0]    req_dst;
    logic [AMT_W*NT-1:0]    req_amt;
    logic [NT-1:0]          gnt;
    logic [NT-1:0]          done;
    logic [1:0]             rsp_status;
    logic [BAL_W-1:0]       rsp_balance;
    logic                   busy;
    logic                   mem_en;
    logic                   mem_we;
    logic [ACC_W-1:0]       mem_addr;
    logic [BAL_W-1:0]       mem_wdata;
    logic [BAL_W-1:0]       mem_rdata;

    atm_ledger_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_op      (req_op),
        .req_src     (req_src),
        .req_dst     (req_dst),
        .req_amt     (req_amt),
        .gnt         (gnt),
        .done        (done),
        .rsp_status  (rsp_status),
        .rsp_balance (rsp_balance),
        .busy        (busy),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Balance RAM model with a write/read log.
    logic [BAL_W-1:0] ledger [16];
    logic             pl_en = 1'b0;
    logic [3:0]       pl_addr = '0;
    logic [BAL_W-1:0] pl_data = '0;
    int               wr_cyc[$];
    int               wr_addr[$];
    int               wr_data[$];
    int               n_rd = 0;

    always @(posedge clk) begin
        if (pl_en) ledger[pl_addr] <= pl_data;
        if (mem_en) begin
            if (mem_we) begin
                ledger[mem_addr] <= mem_wdata;
                wr_cyc.push_back(cyc);
                wr_addr.push_back(int'(mem_addr));
                wr_data.push_back(int'(mem_wdata));
            end else begin
                n_rd <= n_rd + 1;
            end
            mem_rdata <= ledger[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic preload(input int a, input int d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a[3:0];
        pl_data = d[BAL_W-1:0];
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic set_fields(input int t, input int op, input int src, input int dst, input int amt);
        req_op[t*2 +: 2]          = op[1:0];
        req_src[t*ACC_W +: ACC_W] = src[ACC_W-1:0];
        req_dst[t*ACC_W +: ACC_W] = dst[ACC_W-1:0];
        req_amt[t*AMT_W +: AMT_W] = amt[AMT_W-1:0];
    endtask

    task automatic wait_gnt(output logic ok);
        int n;
        n = 0;
        while (gnt == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (gnt != '0);
        chk("gnt_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(output logic ok);
        int n;
        n = 0;
        while (done == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (done != '0);
        chk("done_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_status"}, 32'(rsp_status), 32'd0);
        chk({tag, "_balance"}, 32'(rsp_balance), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    typedef struct {
        int term; int op; int src; int dst; int amt;
        int st; int bal; int lat; int nrd; int nwr; int dbal;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   gc, dc, rd0, wb;
        int   rr_exp[5];
        int   last_done;

        //             term op src dst  amt   st  bal   lat rd wr dbal
        vecs[0]  = '{0, 0, 3,  0,  0,    0, 500,   4, 1, 0, -1};
        vecs[1]  = '{1, 1, 3,  0,  200,  0, 300,   5, 1, 1, -1};
        vecs[2]  = '{1, 1, 3,  0,  400,  1, 300,   4, 1, 0, -1};
        vecs[3]  = '{2, 3, 1,  2,  100,  0, 400,   7, 2, 2, 600};
        vecs[4]  = '{3, 0, 12, 0,  0,    3, 0,     1, 0, 0, -1};
        vecs[5]  = '{0, 3, 5,  5,  10,   3, 0,     1, 0, 0, -1};
        vecs[6]  = '{1, 2, 4,  0,  1000, 2, 65000, 4, 1, 0, -1};
        vecs[7]  = '{2, 2, 4,  0,  535,  0, 65535, 5, 1, 1, -1};
        vecs[8]  = '{3, 3, 2,  4,  1,    2, 600,   5, 2, 0, 65535};
        vecs[9]  = '{0, 1, 2,  0,  600,  0, 0,     5, 1, 1, -1};
        vecs[10] = '{1, 1, 2,  0,  0,    0, 0,     5, 1, 1, -1};
        vecs[11] = '{2, 3, 3,  9,  2047, 1, 300,   5, 2, 0, 0};
        vecs[12] = '{3, 3, 3,  10, 5,    3, 0,     1, 0, 0, -1};
        vecs[13] = '{0, 0, 9,  0,  0,    0, 0,     4, 1, 0, -1};
        vecs[14] = '{1, 3, 2,  4,  5,    1, 0,     5, 2, 0, 65535};

        rst_n   = 1'b0;
        req     = '0;
        req_op  = '0;
        req_src = '0;
        req_dst = '0;
        req_amt = '0;

        for (int a = 0; a < 16; a++) preload(a, 0);
        preload(1, 500);
        preload(2, 500);
        preload(3, 500);
        preload(4, 65000);

        chk_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            rd0 = n_rd;
            wb  = wr_cyc.size();
            @(negedge clk);
            set_fields(vecs[i].term, vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].amt);
            req[vecs[i].term] = 1'b1;
            wait_gnt(ok);
            gc = cyc;
            req[vecs[i].term] = 1'b0;
            if (ok) begin
                chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(1 << vecs[i].term));
                chk($sformatf("v%0d_busy_at_gnt", i), 32'(busy), 32'd1);
                wait_done(ok);
                dc = cyc;
                if (ok) begin
                    chk($sformatf("v%0d_done", i), 32'(done), 32'(1 << vecs[i].term));
                    chk($sformatf("v%0d_latency", i), 32'(dc - gc), 32'(vecs[i].lat));
                    chk($sformatf("v%0d_status", i), 32'(rsp_status), 32'(vecs[i].st));
                    chk($sformatf("v%0d_balance", i), 32'(rsp_balance), 32'(vecs[i].bal));
                    chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
                    chk($sformatf("v%0d_reads", i), 32'(n_rd - rd0), 32'(vecs[i].nrd));
                    chk($sformatf("v%0d_writes", i), 32'(wr_cyc.size() - wb), 32'(vecs[i].nwr));
                    if (vecs[i].nwr > 0 && wr_cyc.size() > wb) begin
                        chk($sformatf("v%0d_wr_src_cycle", i), 32'(wr_cyc[wb] - gc),
                            32'((vecs[i].op == 3) ? 5 : 4));
                        chk($sformatf("v%0d_wr_src_addr", i), 32'(wr_addr[wb]), 32'(vecs[i].src));
                        chk($sformatf("v%0d_wr_src_data", i), 32'(wr_data[wb]), 32'(vecs[i].bal));
                    end
                    if (vecs[i].nwr > 1 && wr_cyc.size() > wb + 1) begin
                        chk($sformatf("v%0d_wr_dst_cycle", i), 32'(wr_cyc[wb+1] - gc), 32'd6);
                        chk($sformatf("v%0d_wr_dst_addr", i), 32'(wr_addr[wb+1]), 32'(vecs[i].dst));
                    end
                    if (vecs[i].st != 3) begin
                        chk($sformatf("v%0d_ledger_src", i), 32'(ledger[vecs[i].src]), 32'(vecs[i].bal));
                    end
                    if (vecs[i].dbal >= 0) begin
                        chk($sformatf("v%0d_ledger_dst", i), 32'(ledger[vecs[i].dst]), 32'(vecs[i].dbal));
                    end
                end
            end
        end

        // Round robin: all four at once after reset; terminal 0 re-requests
        // while terminal 1 is being served and must wait behind 2 and 3.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < NT; t++) set_fields(t, 0, 3, 0, 0);
        req = 4'hF;
        rr_exp = '{0, 1, 2, 3, 0};
        last_done = -100;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(ok);
            if (!ok) break;
            gc = cyc;
            chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(1 << rr_exp[k]));
            chk($sformatf("rr%0d_gap", k), {31'd0, (gc > last_done)}, 32'd1);
            req[rr_exp[k]] = 1'b0;
            if (k == 1) req[0] = 1'b1;
            wait_done(ok);
            if (!ok) break;
            chk($sformatf("rr%0d_done", k), 32'(done), 32'(1 << rr_exp[k]));
            last_done = cyc;
        end
        req = '0;

        // Reset while the destination write of a transfer is on the port.
        preload(1, 500);
        preload(2, 500);
        @(negedge clk);
        set_fields(2, 3, 1, 2, 100);
        req[2] = 1'b1;
        wait_gnt(ok);
        gc = cyc;
        req[2] = 1'b0;
        if (ok) begin
            repeat (6) @(negedge clk);
            chk("rst_dst_write_on_port",
                {31'd0, (mem_en && mem_we && mem_addr == 4'd2)}, 32'd1);
            rst_n = 1'b0;
            #1;
            chk_outputs_zero("midop_reset");
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            chk("rst_src_written", 32'(ledger[1]), 32'd400);
            chk("rst_dst_unchanged", 32'(ledger[2]), 32'd500);

            // rr_ptr back at 0: terminal 1 must beat terminal 3.
            set_fields(1, 0, 3, 0, 0);
            set_fields(3, 0, 3, 0, 0);
            req[1] = 1'b1;
            req[3] = 1'b1;
            wait_gnt(ok);
            if (ok) begin
                chk("rst_rr_first_gnt", 32'(gnt), 32'd2);
                req[1] = 1'b0;
                wait_done(ok);
                wait_gnt(ok);
                if (ok) begin
                    chk("rst_rr_second_gnt", 32'(gnt), 32'd8);
                    req[3] = 1'b0;
                    wait_done(ok);
                end
            end
        end
        req = '0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
